// File: rtl/dma_bus_master_if.sv
// ============================================================================
// Module   : dma_bus_master_if
// Brief    : Z80 shared-bus bundle between the DMA engine and the CPU/DMA mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dma_bus_master_if;
    logic        busrq_n;
    logic        busak_n;
    logic [15:0] dma_a;
    logic [7:0]  dma_din;
    logic [7:0]  dma_dout;
    logic        dma_mreq_n;
    logic        dma_iorq_n;
    logic        dma_rd_n;
    logic        dma_wr_n;

    modport master (
        output busrq_n, dma_a, dma_dout, dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n,
        input  busak_n, dma_din
    );

    modport slave (
        input  busrq_n, dma_a, dma_dout, dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n,
        output busak_n, dma_din
    );
endinterface

`default_nettype wire

// File: rtl/dma_bus_master.sv
// ============================================================================
// Module   : dma_bus_master
// Brief    : Register-configured block-transfer engine; seizes the Z80 bus and
//            copies bytes with 6-clock read-then-write cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_bus_master #(
    parameter logic [7:0] DMACTRL = 8'hA0,
    parameter logic [7:0] DMASRC  = 8'hA1,
    parameter logic [7:0] DMADST  = 8'hA2,
    parameter logic [7:0] DMALEN  = 8'hA3,
    parameter logic [7:0] DMASTAT = 8'hA7
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [7:0]  zxuno_addr,
    input  wire logic        regaddr_changed,
    input  wire logic        zxuno_regrd,
    input  wire logic        zxuno_regwr,
    input  wire logic [7:0]  din,
    output logic      [7:0]  dout,
    output logic             oe_n,
    dma_bus_master_if.master bus,
    output logic             done_irq
);

    localparam logic [3:0] S_IDLE = 4'd0, S_REQ = 4'd1, S_RD0 = 4'd2, S_RD1 = 4'd3,
                           S_G0   = 4'd4, S_WR0 = 4'd5, S_WR1 = 4'd6, S_G1  = 4'd7,
                           S_DONE = 4'd8;

    logic [3:0]  r_state, w_state_nxt;
    logic [15:0] r_src, r_dst, r_len, r_dma_a, w_src_nx, w_dst_nx, w_dma_a_nx;
    logic [7:0]  r_ctrl, r_data, r_dma_dout, w_dma_dout_nx, w_rd_byte;
    logic        r_ptr, r_busy, r_done, r_abort, r_abort_pend, r_src_io, r_dst_io;
    logic        r_busrq_n, r_mreq_n, r_iorq_n, r_rd_n, r_wr_n;
    logic        w_busrq_n_nx, w_mreq_n_nx, w_iorq_n_nx, w_rd_n_nx, w_wr_n_nx;
    logic        w_sel_ctrl, w_sel_src, w_sel_dst, w_sel_len, w_sel_stat, w_sel16;
    logic        w_wr_ctrl, w_run_req, w_abort_req, w_step, w_enter_done, w_rd_ph, w_wr_ph;

    assign w_sel_ctrl  = (zxuno_addr == DMACTRL);
    assign w_sel_src   = (zxuno_addr == DMASRC);
    assign w_sel_dst   = (zxuno_addr == DMADST);
    assign w_sel_len   = (zxuno_addr == DMALEN);
    assign w_sel_stat  = (zxuno_addr == DMASTAT);
    assign w_sel16     = w_sel_src | w_sel_dst | w_sel_len;
    assign w_wr_ctrl   = zxuno_regwr & w_sel_ctrl;
    assign w_run_req   = w_wr_ctrl & din[0] & (r_state == S_IDLE);
    assign w_abort_req = w_wr_ctrl & ~din[0] & r_busy;
    // G1 with the bus still held commits the byte and advances the counters
    assign w_step      = (r_state == S_G1) & ~bus.busak_n;
    assign w_src_nx    = (w_step & ~r_src_io) ? r_src + 16'd1 : r_src;
    assign w_dst_nx    = (w_step & ~r_dst_io) ? r_dst + 16'd1 : r_dst;
    assign w_enter_done = (w_state_nxt == S_DONE) & (r_state != S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_run_req) w_state_nxt = (r_len == 16'd0) ? S_DONE : S_REQ;
            S_REQ: begin
                if (r_abort_pend | w_abort_req) w_state_nxt = S_DONE;
                else if (!bus.busak_n)          w_state_nxt = S_RD0;
            end
            S_RD0, S_RD1, S_G0, S_WR0, S_WR1:
                w_state_nxt = bus.busak_n ? S_REQ : r_state + 4'd1;
            S_G1: begin
                if (bus.busak_n) w_state_nxt = S_REQ;
                else if ((r_len == 16'd1) | r_abort_pend | w_abort_req) w_state_nxt = S_DONE;
                else w_state_nxt = S_RD0;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state and registered so they never glitch
    always_comb begin
        w_rd_ph       = (w_state_nxt == S_RD0) | (w_state_nxt == S_RD1);
        w_wr_ph       = (w_state_nxt == S_WR0) | (w_state_nxt == S_WR1);
        w_busrq_n_nx  = ~((w_state_nxt >= S_REQ) & (w_state_nxt <= S_G1));
        w_rd_n_nx     = ~w_rd_ph;
        w_wr_n_nx     = ~w_wr_ph;
        w_mreq_n_nx   = ~((w_rd_ph & ~r_src_io) | (w_wr_ph & ~r_dst_io));
        w_iorq_n_nx   = ~((w_rd_ph & r_src_io) | (w_wr_ph & r_dst_io));
        w_dma_a_nx    = r_dma_a;
        w_dma_dout_nx = r_dma_dout;
        if (w_rd_ph) w_dma_a_nx = w_src_nx;
        else if (w_wr_ph | (w_state_nxt == S_G0)) w_dma_a_nx = w_dst_nx;
        if (w_wr_ph) w_dma_dout_nx = r_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busrq_n <= 1'b1; r_mreq_n <= 1'b1; r_iorq_n <= 1'b1;
            r_rd_n    <= 1'b1; r_wr_n   <= 1'b1;
            r_dma_a   <= 16'h0000; r_dma_dout <= 8'h00;
        end else begin
            r_busrq_n <= w_busrq_n_nx; r_mreq_n <= w_mreq_n_nx; r_iorq_n <= w_iorq_n_nx;
            r_rd_n    <= w_rd_n_nx;    r_wr_n   <= w_wr_n_nx;
            r_dma_a   <= w_dma_a_nx;   r_dma_dout <= w_dma_dout_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src <= 16'h0; r_dst <= 16'h0; r_len <= 16'h0; r_ctrl <= 8'h0; r_data <= 8'h0;
            r_ptr <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0; r_abort <= 1'b0;
            r_abort_pend <= 1'b0; r_src_io <= 1'b0; r_dst_io <= 1'b0;
        end else begin
            if (regaddr_changed)                           r_ptr <= 1'b0;
            else if ((zxuno_regrd | zxuno_regwr) & w_sel16) r_ptr <= ~r_ptr;

            if (zxuno_regwr & ~r_busy) begin
                if (w_sel_src) begin if (r_ptr) r_src[15:8] <= din; else r_src[7:0] <= din; end
                if (w_sel_dst) begin if (r_ptr) r_dst[15:8] <= din; else r_dst[7:0] <= din; end
                if (w_sel_len) begin if (r_ptr) r_len[15:8] <= din; else r_len[7:0] <= din; end
            end
            if (w_wr_ctrl) r_ctrl <= din;

            if (w_run_req & (r_len != 16'd0)) begin
                r_busy   <= 1'b1;
                r_src_io <= din[2];
                r_dst_io <= din[3];
            end
            if ((r_state == S_RD1) & ~bus.busak_n) r_data <= bus.dma_din;
            if (w_step) begin
                r_src <= w_src_nx;
                r_dst <= w_dst_nx;
                r_len <= r_len - 16'd1;
            end

            if (w_enter_done) begin
                r_done       <= 1'b1;
                r_abort      <= r_abort_pend | w_abort_req;
                r_busy       <= 1'b0;
                r_abort_pend <= 1'b0;
            end else begin
                if (w_abort_req) r_abort_pend <= 1'b1;
                if (zxuno_regrd & w_sel_stat) begin
                    r_done  <= 1'b0;
                    r_abort <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_rd_byte = 8'hFF;
        if (w_sel_ctrl)      w_rd_byte = r_ctrl;
        else if (w_sel_src)  w_rd_byte = r_ptr ? r_src[15:8] : r_src[7:0];
        else if (w_sel_dst)  w_rd_byte = r_ptr ? r_dst[15:8] : r_dst[7:0];
        else if (w_sel_len)  w_rd_byte = r_ptr ? r_len[15:8] : r_len[7:0];
        else if (w_sel_stat) w_rd_byte = {r_done, r_abort, r_busy, 5'b00000};
    end

    assign oe_n     = ~(zxuno_regrd & (w_sel_ctrl | w_sel16 | w_sel_stat));
    assign dout     = oe_n ? 8'hFF : w_rd_byte;
    assign done_irq = (r_state == S_DONE);

    assign bus.busrq_n    = r_busrq_n;
    assign bus.dma_a      = r_dma_a;
    assign bus.dma_dout   = r_dma_dout;
    assign bus.dma_mreq_n = r_mreq_n;
    assign bus.dma_iorq_n = r_iorq_n;
    assign bus.dma_rd_n   = r_rd_n;
    assign bus.dma_wr_n   = r_wr_n;

endmodule

`default_nettype wire

// File: tb/tb_dma_bus_master.sv
// ============================================================================
// Module   : tb_dma_bus_master
// Brief    : Scoreboard bench for dma_bus_master with a memory/IO bus model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_bus_master;

    localparam logic [7:0] c_ctrl = 8'hA0, c_src = 8'hA1, c_dst = 8'hA2,
                           c_len  = 8'hA3, c_stat = 8'hA7;
    localparam logic [1:0] c_k_rd = 2'd0, c_k_wr = 2'd1, c_k_reg = 2'd2, c_k_irq = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] val;
    } ev_t;

    logic       clk, rst;
    logic [7:0] zxuno_addr, din, dout;
    logic       regaddr_changed, zxuno_regrd, zxuno_regwr, oe_n, done_irq;
    logic [7:0] mem [0:65535];
    logic [7:0] io  [0:255];
    ev_t        q[$];
    int         checks, errors, irq_seen, irq_base;
    bit         hold_off, rq_low;

    dma_bus_master_if bus ();

    dma_bus_master u_dut (
        .clk             (clk),
        .rst             (rst),
        .zxuno_addr      (zxuno_addr),
        .regaddr_changed (regaddr_changed),
        .zxuno_regrd     (zxuno_regrd),
        .zxuno_regwr     (zxuno_regwr),
        .din             (din),
        .dout            (dout),
        .oe_n            (oe_n),
        .bus             (bus),
        .done_irq        (done_irq)
    );

    assign bus.dma_din = (bus.dma_iorq_n == 1'b0) ? io[bus.dma_a[7:0]] : mem[bus.dma_a];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU grants the bus one clock after the request unless the bench withholds it
    initial begin
        bus.busak_n = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.busak_n = hold_off ? 1'b1 : bus.busrq_n;
        end
    end

    function automatic void expect_ev(input logic [1:0] k, input logic [31:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endfunction

    function automatic void got(input logic [1:0] k, input logic [31:0] v);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d actual=%h required=none", k, v);
        end else begin
            e = q.pop_front();
            if (e.kind !== k || e.val !== v) begin
                errors++;
                $display("FAIL event actual kind=%0d val=%h required kind=%0d val=%h",
                         k, v, e.kind, e.val);
            end
        end
    endfunction

    // Monitor: every bus cycle start, register read and done pulse is scored in order
    initial begin
        bit prev_rd, prev_wr;
        prev_rd = 1'b1;
        prev_wr = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.busrq_n == 1'b0) rq_low = 1'b1;
            if (!bus.dma_rd_n && prev_rd)
                got(c_k_rd, {14'b0, bus.dma_mreq_n, bus.dma_iorq_n, bus.dma_a});
            if (!bus.dma_wr_n && prev_wr) begin
                got(c_k_wr, {6'b0, bus.dma_mreq_n, bus.dma_iorq_n, bus.dma_a, bus.dma_dout});
                if (!bus.dma_mreq_n) mem[bus.dma_a] = bus.dma_dout;
            end
            if (!oe_n) got(c_k_reg, {24'b0, dout});
            if (done_irq) begin
                got(c_k_irq, 32'h0);
                irq_seen++;
            end
            prev_rd = bus.dma_rd_n;
            prev_wr = bus.dma_wr_n;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Register-port tasks: all are entered and left 1 time unit after a rising edge
    task automatic sel(input logic [7:0] a);
        zxuno_addr = a; regaddr_changed = 1'b1;
        @(posedge clk); #1 regaddr_changed = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        din = d; zxuno_regwr = 1'b1;
        @(posedge clk); #1 zxuno_regwr = 1'b0;
    endtask

    task automatic rd();
        zxuno_regrd = 1'b1;
        @(posedge clk); #1 zxuno_regrd = 1'b0;
    endtask

    task automatic wr16(input logic [7:0] a, input logic [15:0] v);
        sel(a); wr(v[7:0]); wr(v[15:8]);
    endtask

    task automatic rd16(input logic [7:0] a, input logic [15:0] v);
        expect_ev(c_k_reg, {24'b0, v[7:0]});
        expect_ev(c_k_reg, {24'b0, v[15:8]});
        sel(a); rd(); rd();
    endtask

    task automatic rd8(input logic [7:0] a, input logic [7:0] v);
        expect_ev(c_k_reg, {24'b0, v});
        sel(a); rd();
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        wr16(c_src, s); wr16(c_dst, d); wr16(c_len, n);
    endtask

    task automatic start(input logic [7:0] c);
        irq_base = irq_seen;
        sel(c_ctrl); wr(c);
    endtask

    task automatic wait_irq(input string name);
        int n = 0;
        while (irq_seen == irq_base && n < 300) begin
            @(posedge clk); #1 n++;
        end
        chk(name, 32'(irq_seen != irq_base), 32'd1);
    endtask

    task automatic wait_strobe(input bit want_wr, input string name);
        int n = 0;
        while (((want_wr ? bus.dma_wr_n : bus.dma_rd_n) != 1'b0) && n < 100) begin
            @(posedge clk); #1 n++;
        end
        chk(name, 32'(n < 100), 32'd1);
    endtask

    // Memory-space read and write events: {mreq_n,iorq_n} = 2'b01
    function automatic logic [31:0] ev_rd(input logic [1:0] strb, input logic [15:0] a);
        return {14'b0, strb, a};
    endfunction

    function automatic logic [31:0] ev_wr(input logic [15:0] a, input logic [7:0] d);
        return {6'b0, 2'b01, a, d};
    endfunction

    initial begin
        checks = 0; errors = 0; irq_seen = 0; irq_base = 0; hold_off = 1'b0; rq_low = 1'b0;
        rst = 1'b1; zxuno_addr = 8'h00; din = 8'h00;
        regaddr_changed = 1'b0; zxuno_regrd = 1'b0; zxuno_regwr = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) io[i] = 8'h00;
        mem[16'h8000] = 8'h11; mem[16'h8001] = 8'h22; mem[16'h8002] = 8'h33;
        io[8'hFE] = 8'hA5;
        mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hC3;
        mem[16'h1000] = 8'h9E;
        mem[16'h3000] = 8'h77; mem[16'h3001] = 8'h88;
        mem[16'h7000] = 8'h4B;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busrq_n", 32'(bus.busrq_n), 32'd1);
        chk("rst_strobes", {28'b0, bus.dma_mreq_n, bus.dma_iorq_n, bus.dma_rd_n, bus.dma_wr_n}, 32'hF);
        chk("rst_dma_a_dout", {8'b0, bus.dma_a, bus.dma_dout}, 32'h0);
        chk("rst_dout_oe", {23'b0, dout, oe_n}, {23'b0, 8'hFF, 1'b1});
        chk("rst_done_irq", 32'(done_irq), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        rd8(c_stat, 8'h00);
        rd16(c_src, 16'h0000);

        // Plain memory-to-memory copy of three bytes
        expect_ev(c_k_rd, ev_rd(2'b01, 16'h8000)); expect_ev(c_k_wr, ev_wr(16'hC000, 8'h11));
        expect_ev(c_k_rd, ev_rd(2'b01, 16'h8001)); expect_ev(c_k_wr, ev_wr(16'hC001, 8'h22));
        expect_ev(c_k_rd, ev_rd(2'b01, 16'h8002)); expect_ev(c_k_wr, ev_wr(16'hC002, 8'h33));
        expect_ev(c_k_irq, 32'h0);
        setup(16'h8000, 16'hC000, 16'h0003);
        start(8'h01);
        chk("busrq_after_run", 32'(bus.busrq_n), 32'd0);
        wait_irq("t1_irq");
        chk("t1_busrq_released", 32'(bus.busrq_n), 32'd1);
        rd16(c_len, 16'h0000); rd16(c_src, 16'h8003); rd16(c_dst, 16'hC003);

        // Zero length: no request, done pulse, status read clears
        rq_low = 1'b0;
        expect_ev(c_k_irq, 32'h0);
        wr16(c_len, 16'h0000);
        start(8'h01);
        wait_irq("t2_irq");
        chk("t2_no_busrq", 32'(rq_low), 32'd0);
        rd8(c_stat, 8'h80);
        rd8(c_stat, 8'h00);

        // IO source: address held, iorq on reads, mreq on writes
        expect_ev(c_k_rd, ev_rd(2'b10, 16'h00FE)); expect_ev(c_k_wr, ev_wr(16'h4000, 8'hA5));
        expect_ev(c_k_rd, ev_rd(2'b10, 16'h00FE)); expect_ev(c_k_wr, ev_wr(16'h4001, 8'hA5));
        expect_ev(c_k_irq, 32'h0);
        setup(16'h00FE, 16'h4000, 16'h0002);
        start(8'h05);
        wait_irq("t3_irq");
        rd16(c_src, 16'h00FE); rd16(c_dst, 16'h4002);

        // Source address wraps FFFF -> 0000
        expect_ev(c_k_rd, ev_rd(2'b01, 16'hFFFF)); expect_ev(c_k_wr, ev_wr(16'h5000, 8'h5A));
        expect_ev(c_k_rd, ev_rd(2'b01, 16'h0000)); expect_ev(c_k_wr, ev_wr(16'h5001, 8'hC3));
        expect_ev(c_k_irq, 32'h0);
        setup(16'hFFFF, 16'h5000, 16'h0002);
        start(8'h01);
        wait_irq("t4_irq");
        rd16(c_src, 16'h0001);

        // Abort during WR0 of the first byte of five
        expect_ev(c_k_rd, ev_rd(2'b01, 16'h1000)); expect_ev(c_k_wr, ev_wr(16'h2000, 8'h9E));
        expect_ev(c_k_irq, 32'h0);
        setup(16'h1000, 16'h2000, 16'h0005);
        start(8'h01);
        wait_strobe(1'b1, "t5_wr0_seen");
        wr(8'h00);
        wait_irq("t5_irq");
        rd8(c_stat, 8'hC0);
        rd16(c_len, 16'h0004);

        // Bus lost during RD1, byte replayed after re-grant
        expect_ev(c_k_rd, ev_rd(2'b01, 16'h3000));
        expect_ev(c_k_rd, ev_rd(2'b01, 16'h3000)); expect_ev(c_k_wr, ev_wr(16'h6000, 8'h77));
        expect_ev(c_k_rd, ev_rd(2'b01, 16'h3001)); expect_ev(c_k_wr, ev_wr(16'h6001, 8'h88));
        expect_ev(c_k_irq, 32'h0);
        setup(16'h3000, 16'h6000, 16'h0002);
        start(8'h01);
        wait_strobe(1'b0, "t6_rd0_seen");
        @(posedge clk); #1 hold_off = 1'b1;
        @(posedge clk); #1;
        chk("t6_strobes_released", {30'b0, bus.dma_rd_n, bus.dma_mreq_n}, 32'h3);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_busrq_held", 32'(bus.busrq_n), 32'd0);
        hold_off = 1'b0;
        wait_irq("t6_irq");
        chk("t6_mem", {16'b0, mem[16'h6000], mem[16'h6001]}, 32'h7788);

        // Asynchronous reset in WR1
        expect_ev(c_k_rd, ev_rd(2'b01, 16'h7000)); expect_ev(c_k_wr, ev_wr(16'h7100, 8'h4B));
        setup(16'h7000, 16'h7100, 16'h0004);
        start(8'h01);
        wait_strobe(1'b1, "t7_wr0_seen");
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("t7_rst_bus", {13'b0, bus.dma_wr_n, bus.busrq_n, 1'b0, bus.dma_a}, {13'b0, 3'b110, 16'h0});
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        rd16(c_src, 16'h0000); rd16(c_dst, 16'h0000); rd16(c_len, 16'h0000);
        rd8(c_stat, 8'h00);

        repeat (3) @(posedge clk);
        chk("t1_mem", {8'b0, mem[16'hC000], mem[16'hC001], mem[16'hC002]}, 32'h112233);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
